dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 41 ++++
 rtl/rsp_fifo.sv | 71 +++++++
 rtl/dmem_responder.sv | 123 ++++++++++++
 tb/tb_dmem_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Shared SoC constants and core data request/response structs.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package dmem_responder_pkg;

  localparam logic [31:0] SocMemBaseAddr = 32'h0001_0000;
  localparam int unsigned SocMemNumWords = 4096;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  amo;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  size;
  } dmem_req_chan_t;

  typedef struct packed {
    dmem_req_chan_t q;
    logic           q_valid;
    logic           p_ready;
  } dmem_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic        error;
  } dmem_rsp_chan_t;

  typedef struct packed {
    logic           q_ready;
    dmem_rsp_chan_t p;
    logic           p_valid;
  } dmem_rsp_t;

endpackage

`default_nettype wire

// File: rtl/rsp_fifo.sv
// ============================================================================
// Module      : rsp_fifo
// Description : Fall-through response buffer; an empty FIFO forwards push data.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rsp_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 33
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_q;
  logic [PtrW-1:0]  wr_q;
  logic [CntW-1:0]  cnt_q;
  logic             empty;
  logic             bypass;
  logic             write_en;
  logic             read_en;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty    = (cnt_q == '0);
  assign valid_o  = !empty || push_i;
  assign data_o   = empty ? data_i : mem_q[rd_q];
  // A push into an empty FIFO that is popped the same cycle never gets stored.
  assign bypass   = empty && push_i && pop_i;
  assign write_en = push_i && !bypass;
  assign read_en  = pop_i && !empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (write_en) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= next_ptr(wr_q);
      end
      if (read_en) begin
        rd_q <= next_ptr(rd_q);
      end
      case ({write_en, read_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder: core request channel to single-port SRAM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned           AddrWidth   = 32,
  parameter int unsigned           DataWidth   = 32,
  parameter logic [AddrWidth-1:0]  MemBaseAddr = SocMemBaseAddr,
  parameter int unsigned           MemNumWords = SocMemNumWords,
  parameter int unsigned           RspDepth    = 2,
  parameter type                   dreq_t      = dmem_req_t,
  parameter type                   drsp_t      = dmem_rsp_t
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  dreq_t                          data_req_i,
  output drsp_t                          data_rsp_o,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [$clog2(MemNumWords)-1:0] mem_addr_o,
  output logic [DataWidth-1:0]           mem_wdata_o,
  output logic [DataWidth/8-1:0]         mem_be_o,
  input  logic [DataWidth-1:0]           mem_rdata_i
);

  localparam int unsigned    MemAw   = $clog2(MemNumWords);
  localparam int unsigned    CreditW = $clog2(RspDepth + 1);
  localparam logic [AddrWidth:0] MemEnd =
    {1'b0, MemBaseAddr} + (AddrWidth + 1)'(4 * MemNumWords);

  logic [CreditW-1:0]   credit_q;
  logic                 q_ready;
  logic                 q_hs;
  logic                 p_valid;
  logic                 p_hs;
  logic                 in_range;
  logic                 mem_access;
  logic [AddrWidth-1:0] offset;
  logic                 inflight_q;
  logic                 inflight_read_q;
  logic                 inflight_err_q;
  logic [DataWidth:0]   push_entry;
  logic [DataWidth:0]   head_entry;
  logic                 unused_bits;

  assign q_ready = (credit_q < CreditW'(RspDepth));
  // Reset gating keeps the SRAM port quiet while rst_ni is low.
  assign q_hs    = data_req_i.q_valid && q_ready && rst_ni;
  assign p_hs    = p_valid && data_req_i.p_ready;

  assign in_range = ({1'b0, data_req_i.q.addr} >= {1'b0, MemBaseAddr}) &&
                    ({1'b0, data_req_i.q.addr} <  MemEnd);
  assign mem_access = q_hs && in_range && (data_req_i.q.amo == '0);
  assign offset     = data_req_i.q.addr - MemBaseAddr;

  assign mem_req_o   = mem_access;
  assign mem_we_o    = mem_access && data_req_i.q.write;
  assign mem_addr_o  = mem_access ? offset[MemAw+1:2] : '0;
  assign mem_wdata_o = mem_access ? data_req_i.q.data : '0;
  assign mem_be_o    = !mem_access        ? '0 :
                       data_req_i.q.write ? data_req_i.q.strb : '1;

  assign unused_bits = ^{data_req_i.q.size, offset[AddrWidth-1:MemAw+2], offset[1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_read_q <= 1'b0;
      inflight_err_q  <= 1'b0;
    end else begin
      inflight_q      <= q_hs;
      inflight_read_q <= !data_req_i.q.write;
      inflight_err_q  <= !(in_range && (data_req_i.q.amo == '0));
      case ({q_hs, p_hs})
        2'b10:   credit_q <= credit_q + 1'b1;
        2'b01:   credit_q <= credit_q - 1'b1;
        default: credit_q <= credit_q;
      endcase
    end
  end

  // Entry layout is {data, error}; SRAM read data is only valid this cycle.
  always_comb begin
    push_entry = '0;
    if (inflight_q) begin
      if (inflight_err_q) begin
        push_entry = {{DataWidth{1'b0}}, 1'b1};
      end else if (inflight_read_q) begin
        push_entry = {mem_rdata_i, 1'b0};
      end
    end
  end

  rsp_fifo #(
    .Depth (RspDepth),
    .Width (DataWidth + 1)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (inflight_q),
    .data_i  (push_entry),
    .pop_i   (data_req_i.p_ready),
    .valid_o (p_valid),
    .data_o  (head_entry)
  );

  always_comb begin
    data_rsp_o         = '0;
    data_rsp_o.q_ready = q_ready;
    data_rsp_o.p_valid = p_valid;
    data_rsp_o.p.data  = head_entry[DataWidth:1];
    data_rsp_o.p.error = head_entry[0];
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Scoreboard bench for dmem_responder with a behavioural SRAM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int          NW   = 4096;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  dmem_req_t   req;
  dmem_rsp_t   rsp;
  logic        mem_req;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  logic [31:0] sram    [NW];
  logic [31:0] exp_mem [NW];
  exp_t        sb [$];
  int          rsp_times [$];
  int          tests = 0;
  int          errors = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .data_req_i  (req),
    .data_rsp_o  (rsp),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_be_o    (mem_be),
    .mem_rdata_i (mem_rdata)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (!(req.q_valid && rsp.q_ready)) check("mem_req_idle", {63'd0, mem_req}, 64'd0);
      if (rsp.p_valid && req.p_ready) begin
        rsp_times.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_data", {32'd0, rsp.p.data}, {32'd0, e.data});
          check("rsp_err", {63'd0, rsp.p.error}, {63'd0, e.err});
        end
      end
    end
  end

  task automatic issue(input logic [31:0] addr, input logic wr, input logic [3:0] amo,
                       input logic [31:0] data, input logic [3:0] strb);
    logic        ok;
    logic [31:0] woff;
    exp_t        e;
    bit          acc;
    acc = 1'b0;
    req.q.addr  = addr;
    req.q.write = wr;
    req.q.amo   = amo;
    req.q.data  = data;
    req.q.strb  = strb;
    req.q.size  = 2'd2;
    req.q_valid = 1'b1;
    ok   = (addr >= BASE) && ({1'b0, addr} < ({1'b0, BASE} + 33'd16384)) && (amo == 4'd0);
    woff = (addr - BASE) >> 2;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (rsp.q_ready) begin
        acc = 1'b1;
        check("mem_req", {63'd0, mem_req}, {63'd0, ok});
        if (ok) begin
          check("mem_we", {63'd0, mem_we}, {63'd0, wr});
          check("mem_addr", {52'd0, mem_addr}, {52'd0, woff[11:0]});
          check("mem_be", {60'd0, mem_be}, {60'd0, (wr ? strb : 4'hF)});
          if (wr) begin
            check("mem_wdata", {32'd0, mem_wdata}, {32'd0, data});
            for (int b = 0; b < 4; b++) begin
              if (strb[b]) exp_mem[woff[11:0]][8*b +: 8] = data[8*b +: 8];
            end
            e = '{32'd0, 1'b0};
          end else begin
            e = '{exp_mem[woff[11:0]], 1'b0};
          end
        end else begin
          e = '{32'd0, 1'b1};
        end
        sb.push_back(e);
      end
    end
    if (!acc) check("q_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req.q_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_qready"}, {63'd0, rsp.q_ready}, 64'd1);
    check({tag, "_pvalid"}, {63'd0, rsp.p_valid}, 64'd0);
    check({tag, "_pdata_err"}, {31'd0, rsp.p.data, rsp.p.error}, 64'd0);
    check({tag, "_mem"}, {mem_req, mem_we, mem_addr, mem_be, mem_wdata}, 64'd0);
  endtask

  initial begin
    req = '0;
    req.p_ready = 1'b1;
    mem_rdata = '0;
    for (int i = 0; i < NW; i++) begin
      sram[i]    = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
      exp_mem[i] = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
    end
    sram[5]    = 32'hDEAD_BEEF;
    exp_mem[5] = 32'hDEAD_BEEF;

    #12;
    check_reset_outputs("in_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");
    @(posedge clk);
    #1;

    // Single read, then confirm the response shows up one cycle later.
    issue(32'h0001_0014, 1'b0, 4'd0, 32'd0, 4'd0);
    req.q_valid = 1'b0;
    @(negedge clk);
    check("rd_latency_pvalid", {63'd0, rsp.p_valid}, 64'd1);
    @(posedge clk);
    #1;

    // Byte write followed by read-back of the same word.
    issue(32'h0001_0008, 1'b1, 4'd0, 32'h0000_AB00, 4'b0010);
    idle(1);
    issue(32'h0001_0008, 1'b0, 4'd0, 32'd0, 4'd0);
    idle(1);
    check("byte1_model", {56'd0, exp_mem[2][15:8]}, 64'hAB);

    // Error paths: below the window and an AMO inside it.
    issue(32'h0000_0000, 1'b0, 4'd0, 32'd0, 4'd0);
    issue(32'h0001_0000, 1'b1, 4'h3, 32'h1234_5678, 4'hF);
    idle(2);

    // Backpressure: two accepted, third stalls until responses drain.
    req.p_ready = 1'b0;
    issue(32'h0001_0010, 1'b0, 4'd0, 32'd0, 4'd0);
    issue(32'h0001_0014, 1'b0, 4'd0, 32'd0, 4'd0);
    req.q.addr  = 32'h0001_0018;
    req.q.write = 1'b0;
    req.q_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bp_qready_low", {63'd0, rsp.q_ready}, 64'd0);
      check("bp_pvalid_held", {31'd0, rsp.p_valid, rsp.p.data}, {31'd1, exp_mem[4]});
      @(posedge clk);
      #1;
    end
    req.p_ready = 1'b1;
    issue(32'h0001_0018, 1'b0, 4'd0, 32'd0, 4'd0);
    idle(3);

    // Throughput up to the last word of the window, then just past it.
    rsp_times.delete();
    for (int k = 0; k < 16; k++) begin
      issue(32'h0001_3FC0 + 32'(4 * k), 1'b0, 4'd0, 32'd0, 4'd0);
    end
    idle(3);
    check("tput_count", 64'(rsp_times.size()), 64'd16);
    if (rsp_times.size() == 16) check("tput_span", 64'(rsp_times[15] - rsp_times[0]), 64'd15);
    issue(32'h0001_4000, 1'b0, 4'd0, 32'd0, 4'd0);
    idle(2);

    // Reset with two responses pending.
    req.p_ready = 1'b0;
    issue(32'h0001_0020, 1'b0, 4'd0, 32'd0, 4'd0);
    issue(32'h0001_0024, 1'b0, 4'd0, 32'd0, 4'd0);
    req.q_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_pvalid", {63'd0, rsp.p_valid}, 64'd0);
    check("rst_qready", {63'd0, rsp.q_ready}, 64'd1);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    req.p_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_stale_rsp", {63'd0, rsp.p_valid}, 64'd0);
    end
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

`default_nettype wire
